// File: rtl/div_req_ctrl.sv
// div_req_ctrl: execute-stage initiator for the radix-2 SRT divider.
// Accepts one div/mod op at a time, drives divider slot 1, waits for the
// qualified completion and returns the result with its tag. A flushed op is
// kept on the divider (KILL) until it completes so no partial state remains.
// Optional last-result cache: define DIV_REQ_RESULT_CACHE_EN.
module div_req_ctrl #(
   parameter int TAG_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_mod,
   input  logic             req_unsigned,
   input  logic [31:0]      req_x,
   input  logic [31:0]      req_y,
   input  logic [TAG_W-1:0] req_tag,
   output logic [66:0]      es_to_div_bus,
   input  logic [32:0]      div_to_es_bus,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_KILL = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic             r_mod;
   logic             r_unsigned;
   logic [31:0]      r_x;
   logic [31:0]      r_y;
   logic [31:0]      r_result;
   logic [TAG_W-1:0] r_tag;

   logic             w_use_div;
   logic             w_div_ok;
   logic [31:0]      w_div_result;
   logic             w_done;
   logic             w_accept;
   logic             w_capture;
   logic             w_hit;
   logic [31:0]      w_hit_result;

   assign w_div_result = div_to_es_bus[32:1];
   assign w_div_ok     = div_to_es_bus[0];

   // The divider reports ok while idle or gated, so ok only means
   // completion while we are actually requesting and not flushing.
   assign w_use_div = (r_state == S_BUSY) || (r_state == S_KILL);
   assign w_done    = w_div_ok && w_use_div && !flush;

   assign req_ready = (r_state == S_IDLE) && !flush;
   assign w_accept  = req_valid && req_ready;

   // Operand fields are only presented while the request is up.
   assign es_to_div_bus = w_use_div ? {1'b1, r_mod, r_unsigned, r_x, r_y} : 67'd0;

   assign rsp_valid = (r_state == S_DONE);
   assign rsp_data  = r_result;
   assign rsp_tag   = r_tag;
   assign busy      = (r_state != S_IDLE);

`ifdef DIV_REQ_RESULT_CACHE_EN
   logic        r_c_vld;
   logic        r_c_mod;
   logic        r_c_unsigned;
   logic [31:0] r_c_x;
   logic [31:0] r_c_y;
   logic [31:0] r_c_result;

   assign w_hit = r_c_vld && (r_c_mod == req_mod) && (r_c_unsigned == req_unsigned) &&
                  (r_c_x == req_x) && (r_c_y == req_y);
   assign w_hit_result = r_c_result;

   // Remember the last op that completed on the divider; a kill invalidates it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_c_vld      <= 1'b0;
         r_c_mod      <= 1'b0;
         r_c_unsigned <= 1'b0;
         r_c_x        <= 32'd0;
         r_c_y        <= 32'd0;
         r_c_result   <= 32'd0;
      end else if (r_state == S_KILL) begin
         r_c_vld <= 1'b0;
      end else if (w_capture) begin
         r_c_vld      <= 1'b1;
         r_c_mod      <= r_mod;
         r_c_unsigned <= r_unsigned;
         r_c_x        <= r_x;
         r_c_y        <= r_y;
         r_c_result   <= w_div_result;
      end
   end
`else
   assign w_hit        = 1'b0;
   assign w_hit_result = 32'd0;
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; flush beats completion in BUSY and beats rsp_ready in DONE.
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = w_hit ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            if (flush) begin
               w_state_nxt = S_KILL;
            end else if (w_done) begin
               w_capture   = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_KILL: begin
            if (w_done) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_DONE: begin
            if (flush || rsp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Op fields latch on accept and stay constant for the whole divider request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mod      <= 1'b0;
         r_unsigned <= 1'b0;
         r_x        <= 32'd0;
         r_y        <= 32'd0;
         r_tag      <= '0;
         r_result   <= 32'd0;
      end else begin
         if (w_accept) begin
            r_mod      <= req_mod;
            r_unsigned <= req_unsigned;
            r_x        <= req_x;
            r_y        <= req_y;
            r_tag      <= req_tag;
         end
         if (w_accept && w_hit) begin
            r_result <= w_hit_result;
         end else if (w_capture) begin
            r_result <= w_div_result;
         end
      end
   end

endmodule

// File: doc/div_req_ctrl.md
Name: div_req_ctrl

Overview:
- Execute-stage initiator for the radix-2 SRT divider: accepts div/mod ops from issue, drives the divider request bus, waits for completion, returns the result downstream.
- One op in flight at a time. Owns the flush drain so a killed op never leaves the divider holding stale partial state.
- Sits between issue/EX and the divider top; drives divider slot 1 (slot 2 tied to zero by the integrator).

Parameters:
- TAG_W, 6, width of the opaque op tag carried from request to response.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  pipeline flush; kills accepted or pending op
- req_valid  in  1  op offered
- req_ready  out  1  op accepted when req_valid&&req_ready at posedge
- req_mod  in  1  1 = remainder, 0 = quotient
- req_unsigned  in  1  1 = unsigned, 0 = signed
- req_x  in  32  dividend
- req_y  in  32  divisor
- req_tag  in  TAG_W  op tag
- es_to_div_bus  out  67  {use_div, use_mod, is_unsigned, x[31:0], y[31:0]} to divider slot 1
- div_to_es_bus  in  33  {div_result[31:0], div_ok} from divider
- rsp_valid  out  1  result valid
- rsp_ready  in  1  downstream accepts result
- rsp_data  out  32  quotient or remainder
- rsp_tag  out  TAG_W  tag of returned op
- busy  out  1  state != IDLE (stall to issue)

Behaviour:
- Reset (async): state=IDLE; operand, tag and result registers=0; es_to_div_bus=0; rsp_valid=0; busy=0. Reset mid-op abandons the op; the divider shares the reset.
- req_ready = (state==IDLE) && !flush (combinational).
- div_ok is qualified: done = div_ok && use_div && !flush. div_ok is ignored otherwise because the divider reports ok=1 whenever its request is low or gated by flush.
- States:
  - IDLE: on accept, latch mod/unsigned/x/y/tag, go to BUSY.
  - BUSY: use_div=1, operands held constant. flush → KILL. done → capture div_result into rsp_data, go to DONE.
  - KILL: use_div=1, same operands, so the divider finishes and self-resets. done → IDLE; result discarded, no rsp.
  - DONE: use_div=0, rsp_valid=1. rsp_ready → IDLE. flush → IDLE with rsp dropped; flush has priority over rsp_ready.
- es_to_div_bus fields other than use_div are 0 in IDLE and DONE.
- use_div must be low in the cycle after done is sampled. This is guaranteed because BUSY/KILL exit on done, so the divider does not restart the same op.
- Latency: accept at edge E0 → use_div high from E0. Result captured at the edge where done=1 → rsp_valid high the following cycle (registered). New accept is possible in the cycle after the rsp handshake.
- Simultaneous events:
  - flush && done in BUSY: done is masked, state goes to KILL.
  - flush && req_valid in IDLE: not accepted.
- Divide-by-zero: rsp_data is whatever the divider returns; no error flag.

Optional Feature:
- DIV_REQ_RESULT_CACHE_EN.
- Defined: keep last completed {mod, unsigned, x, y, result} plus a valid bit. The valid bit is cleared on reset and when an op is killed in KILL.
- On an IDLE accept whose fields all match the cache: skip BUSY, load rsp_data from the cache, go straight to DONE (rsp_valid one cycle after accept). The divider is not requested.
- Undefined: no cache; every op goes through BUSY.

Test Plan:
- Unsigned div: x=100, y=7, mod=0 → rsp_data=14, rsp_tag echoed. use_div drops the cycle after done; exactly one rsp.
- Unsigned mod: x=100, y=7, mod=1 → rsp_data=2.
- Signed div: x=0xFFFFFFF9 (-7), y=2, unsigned=0 → rsp_data=0xFFFFFFFD (-3).
- Flush 3 cycles after accept → state KILL. use_div stays high with unchanged operands until div_ok, then IDLE, no rsp_valid. A following op 100/7 → 14 (divider not left mid-op).
- Backpressure: rsp_ready=0 for 5 cycles → rsp_valid, rsp_data and rsp_tag stable. req_ready=0 and use_div=0 throughout. Handshake then IDLE.
- Cache (macro on): 100/7 twice back-to-back → second rsp_valid one cycle after accept, use_div never asserted. With the macro off, the second op takes full divider latency.
